// File: rtl/vga_scanout.sv
// 640x480@60 scan-out engine: reads RGB444 words from framebuffer RAM port b with
// 2^SCALE_SHIFT pixel replication and emits pipeline-aligned RGB, HS, VS and frame_start.
module vga_scanout #(
   parameter int          H_ACTIVE    = 640,
   parameter int          H_FP        = 16,
   parameter int          H_SYNC      = 96,
   parameter int          H_BP        = 48,
   parameter int          V_ACTIVE    = 480,
   parameter int          V_FP        = 10,
   parameter int          V_SYNC      = 2,
   parameter int          V_BP        = 33,
   parameter int          SCALE_SHIFT = 2,
   parameter int          FB_WIDTH    = 160,
   parameter logic [15:0] FB_BASE     = 16'h0000,
   parameter int          RD_LATENCY  = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [15:0] address,
   output logic        wren,
   output logic [15:0] data,
   input  logic [15:0] q,
   output logic [3:0]  VGA_R,
   output logic [3:0]  VGA_G,
   output logic [3:0]  VGA_B,
   output logic        HS,
   output logic        VS,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int PIPE    = RD_LATENCY + 2;

   localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS_L   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE_L   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST_L = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_MASK   = HW'((1 << SCALE_SHIFT) - 1);
   localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ALST_L = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] V_SS_L   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE_L   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST_L = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_MASK   = VW'((1 << SCALE_SHIFT) - 1);
   localparam logic [15:0]   FBW16    = 16'(FB_WIDTH);
   // Stage bits: {active, hs_n, vs_n, fs}
   localparam logic [3:0]    STG_RST  = 4'b0110;

   logic          run_q;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic [15:0]   col_q, col_d, row_base_q, row_base_d, addr_q, addr_d, next_base;
   logic [11:0]   rgb_q, rgb_d;
   logic          h_end, v_end, h_act, v_act, v_step;
   logic [3:0]    raw;
   logic [3:0]    stg_q  [PIPE];
   logic [3:0]    stg_in [PIPE];
   logic          q_unused;

   always_comb begin
      h_end  = (hcnt_q == H_LAST_L);
      v_end  = (vcnt_q == V_LAST_L);
      h_act  = (hcnt_q < H_ACT_L);
      v_act  = (vcnt_q < V_ACT_L);
      v_step = v_act && ((vcnt_q & V_MASK) == V_MASK);
      raw    = {h_act && v_act,
                !((hcnt_q >= H_SS_L) && (hcnt_q < H_SE_L)),
                !((vcnt_q >= V_SS_L) && (vcnt_q < V_SE_L)),
                (hcnt_q == '0) && (vcnt_q == V_ACT_L)};

      hcnt_d = h_end ? '0 : hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (h_end) vcnt_d = v_end ? '0 : vcnt_q + 1'b1;

      col_d = col_q;
      if (h_end)
         col_d = '0;
      else if (h_act && ((hcnt_q & H_MASK) == H_MASK))
         col_d = col_q + 16'd1;

      row_base_d = row_base_q;
      if (h_end) begin
         if (v_end)       row_base_d = FB_BASE;
         else if (v_step) row_base_d = row_base_q + FBW16;
      end

      // Outside the visible window the address is parked on the next displayed row.
      if (!v_act || vcnt_q == V_ALST_L) next_base = FB_BASE;
      else if (v_step)                  next_base = row_base_q + FBW16;
      else                              next_base = row_base_q;
      addr_d = raw[3] ? row_base_q + col_q : next_base;

      rgb_d = stg_q[PIPE-2][3] ? q[11:0] : 12'h000;
   end

   // run_q holds the counters on the first edge after reset release so that edge starts (0,0).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_q      <= 1'b0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         col_q      <= '0;
         row_base_q <= FB_BASE;
         addr_q     <= FB_BASE;
         rgb_q      <= '0;
      end else begin
         run_q <= 1'b1;
         if (run_q) begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            rgb_q      <= rgb_d;
         end
      end
   end

   for (genvar gi = 0; gi < PIPE; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
         assign stg_in[gi] = raw;
      end else begin : g_tail
         assign stg_in[gi] = stg_q[gi-1];
      end
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n)   stg_q[gi] <= STG_RST;
         else if (run_q) stg_q[gi] <= stg_in[gi];
      end
   end

   assign address     = addr_q;
   assign wren        = 1'b0;
   assign data        = 16'h0000;
   assign VGA_R       = rgb_q[11:8];
   assign VGA_G       = rgb_q[7:4];
   assign VGA_B       = rgb_q[3:0];
   assign HS          = stg_q[PIPE-1][2];
   assign VS          = stg_q[PIPE-1][1];
   assign frame_start = stg_q[PIPE-1][0];
   assign q_unused    = &{1'b0, q[15:12], stg_q[PIPE-1][3]};

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: one full-size instance plus two shrunk-timing instances
// (RD_LATENCY 1 and 2, one with a wrapping FB_BASE) checked every cycle against an arithmetic model.
module tb_vga_scanout;
   localparam int ND  = 3;
   localparam int REP = 4;

   typedef struct {
      int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, fbw, pipe;
      logic [15:0] base;
   } cfg_t;

   typedef struct {
      int mode;      // 0: all FFFF, 1: single 0ABC word, 2: random
      int cycles;
      int rst_at;    // cycle of a 3-clock mid-frame reset, -1 for none
      int exp_fall [ND];
      int exp_first[ND];
      int exp_cnt  [ND];
   } phase_t;

   cfg_t   cfg[ND];
   phase_t ph[3];

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] addr_w[ND], data_w[ND], q_w[ND];
   logic        wren_w[ND], hs_w[ND], vs_w[ND], fs_w[ND];
   logic [3:0]  r_w[ND], g_w[ND], b_w[ND];
   logic [15:0] mem[ND][0:65535];
   logic [15:0] qs1[ND], qs2[ND];

   int t = -1;
   int n_checks = 0;
   int n_err = 0;
   int first_fall[ND], second_fall[ND], first_rise[ND], first_rgb[ND], rgb_cnt[ND];
   logic prev_hs[ND];

   // RAM port b model: registered read, one extra stage for the latency-2 instance
   always @(posedge clk) begin
      for (int d = 0; d < ND; d++) begin
         qs1[d] <= mem[d][addr_w[d]];
         qs2[d] <= qs1[d];
      end
   end
   assign q_w[0] = qs1[0];
   assign q_w[1] = qs1[1];
   assign q_w[2] = qs2[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) t <= -1;
      else        t <= t + 1;
   end

   vga_scanout u_full (
      .clock(clk), .reset_n(rst_n), .address(addr_w[0]), .wren(wren_w[0]), .data(data_w[0]),
      .q(q_w[0]), .VGA_R(r_w[0]), .VGA_G(g_w[0]), .VGA_B(b_w[0]),
      .HS(hs_w[0]), .VS(vs_w[0]), .frame_start(fs_w[0]));

   vga_scanout #(
      .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(16), .V_FP(2), .V_SYNC(2),
      .V_BP(3), .SCALE_SHIFT(2), .FB_WIDTH(8), .FB_BASE(16'h0000), .RD_LATENCY(1)
   ) u_s1 (
      .clock(clk), .reset_n(rst_n), .address(addr_w[1]), .wren(wren_w[1]), .data(data_w[1]),
      .q(q_w[1]), .VGA_R(r_w[1]), .VGA_G(g_w[1]), .VGA_B(b_w[1]),
      .HS(hs_w[1]), .VS(vs_w[1]), .frame_start(fs_w[1]));

   vga_scanout #(
      .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(16), .V_FP(2), .V_SYNC(2),
      .V_BP(3), .SCALE_SHIFT(2), .FB_WIDTH(8), .FB_BASE(16'hFFF0), .RD_LATENCY(2)
   ) u_s2 (
      .clock(clk), .reset_n(rst_n), .address(addr_w[2]), .wren(wren_w[2]), .data(data_w[2]),
      .q(q_w[2]), .VGA_R(r_w[2]), .VGA_G(g_w[2]), .VGA_B(b_w[2]),
      .HS(hs_w[2]), .VS(vs_w[2]), .frame_start(fs_w[2]));

   function automatic int htot(int d);
      return cfg[d].ha + cfg[d].hfp + cfg[d].hsw + cfg[d].hbp;
   endfunction

   function automatic int vtot(int d);
      return cfg[d].va + cfg[d].vfp + cfg[d].vsw + cfg[d].vbp;
   endfunction

   // Word address the DUT should present for counter state number s of the frame sequence
   function automatic logic [15:0] model_addr(int d, int s);
      int h, v, nl;
      h = s % htot(d);
      v = (s / htot(d)) % vtot(d);
      if (h < cfg[d].ha && v < cfg[d].va)
         return 16'(int'(cfg[d].base) + (v / REP) * cfg[d].fbw + h / REP);
      nl = (v < cfg[d].va - 1) ? v + 1 : 0;
      return 16'(int'(cfg[d].base) + (nl / REP) * cfg[d].fbw);
   endfunction

   // {R,G,B,HS,VS,frame_start} expected in cycle tt
   function automatic logic [14:0] model_video(int d, int tt);
      int s, h, v;
      logic act, hsn, vsn, fs;
      logic [15:0] w;
      if (tt < cfg[d].pipe) return {12'h000, 3'b110};
      s   = tt - cfg[d].pipe;
      h   = s % htot(d);
      v   = (s / htot(d)) % vtot(d);
      act = (h < cfg[d].ha) && (v < cfg[d].va);
      hsn = !(h >= cfg[d].ha + cfg[d].hfp && h < cfg[d].ha + cfg[d].hfp + cfg[d].hsw);
      vsn = !(v >= cfg[d].va + cfg[d].vfp && v < cfg[d].va + cfg[d].vfp + cfg[d].vsw);
      fs  = (h == 0) && (v == cfg[d].va);
      w   = mem[d][model_addr(d, s)];
      return {act ? w[11:0] : 12'h000, hsn, vsn, fs};
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d t=%0d: got %0h expected %0h", name, d, t, act, exp);
      end
   endtask

   // Per-cycle checker and HS / pixel event monitor
   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            logic [15:0] ea;
            logic [14:0] ev;
            ea = (t <= 0) ? cfg[d].base : model_addr(d, t - 1);
            ev = (t < 0) ? {12'h000, 3'b110} : model_video(d, t);
            chk("addr", d, {16'h0, addr_w[d]}, {16'h0, ea});
            chk("video", d, {17'h0, r_w[d], g_w[d], b_w[d], hs_w[d], vs_w[d], fs_w[d]}, {17'h0, ev});
            chk("wr_port", d, {15'h0, wren_w[d], data_w[d]}, 32'h0);
            if (t < 0) begin
               first_fall[d] = -1; second_fall[d] = -1; first_rise[d] = -1;
               first_rgb[d] = -1;  rgb_cnt[d] = 0;      prev_hs[d] = 1'b1;
            end else begin
               if (prev_hs[d] && !hs_w[d]) begin
                  if (first_fall[d] < 0)       first_fall[d] = t;
                  else if (second_fall[d] < 0) second_fall[d] = t;
               end
               if (!prev_hs[d] && hs_w[d] && first_rise[d] < 0) first_rise[d] = t;
               prev_hs[d] = hs_w[d];
               if ({r_w[d], g_w[d], b_w[d]} != 12'h000) begin
                  if (first_rgb[d] < 0) first_rgb[d] = t;
                  rgb_cnt[d]++;
               end
            end
         end
      end
   end

   initial begin
      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 160, 3, 16'h0000};
      cfg[1] = '{32, 4, 6, 6, 16, 2, 2, 3, 8, 3, 16'h0000};
      cfg[2] = '{32, 4, 6, 6, 16, 2, 2, 3, 8, 4, 16'hFFF0};

      ph[0].mode = 0; ph[0].cycles = 2300; ph[0].rst_at = -1;
      ph[1].mode = 1; ph[1].cycles = 5700; ph[1].rst_at = -1;
      ph[2].mode = 2; ph[2].cycles = 2400; ph[2].rst_at = 10 * 48 + 20;
      for (int p = 0; p < 3; p++) begin
         ph[p].exp_fall[0] = 656 + 3;
         ph[p].exp_fall[1] = 36 + 3;
         ph[p].exp_fall[2] = 36 + 4;
         for (int d = 0; d < ND; d++) begin
            ph[p].exp_first[d] = -1;
            ph[p].exp_cnt[d]   = -1;
         end
      end
      // The single 0ABC word covers a 4x4 block at (4..7,4..7); 5 small frames fit in 5700 cycles
      ph[1].exp_first[0] = 4 * 800 + 4 + 3;
      ph[1].exp_first[1] = 4 * 48 + 4 + 3;
      ph[1].exp_first[2] = 4 * 48 + 4 + 4;
      ph[1].exp_cnt[0] = 16;
      ph[1].exp_cnt[1] = 80;
      ph[1].exp_cnt[2] = 80;

      for (int p = 0; p < 3; p++) begin
         @(posedge clk);
         #1 rst_n = 1'b0;
         for (int d = 0; d < ND; d++)
            for (int i = 0; i < 65536; i++)
               mem[d][i] = (ph[p].mode == 0) ? 16'hFFFF :
                           (ph[p].mode == 1) ? 16'h0000 : 16'($urandom);
         if (ph[p].mode == 1) begin
            mem[0][161]      = 16'h0ABC;
            mem[1][9]        = 16'h0ABC;
            mem[2][16'hFFF9] = 16'h0ABC;
         end
         repeat (5) @(posedge clk);
         #1 rst_n = 1'b1;
         for (int c = 0; c < ph[p].cycles; c++) begin
            @(posedge clk);
            if (c == ph[p].rst_at) begin
               #1 rst_n = 1'b0;
               repeat (3) @(posedge clk);
               #1 rst_n = 1'b1;
            end
         end
         @(negedge clk);
         #1;
         for (int d = 0; d < ND; d++) begin
            chk("hs_first_fall", d, first_fall[d], ph[p].exp_fall[d]);
            chk("hs_low_width", d, first_rise[d] - first_fall[d], cfg[d].hsw);
            chk("hs_period", d, second_fall[d] - first_fall[d], htot(d));
            if (ph[p].exp_first[d] >= 0) begin
               chk("rgb_first", d, first_rgb[d], ph[p].exp_first[d]);
               chk("rgb_count", d, rgb_cnt[d], ph[p].exp_cnt[d]);
            end
         end
         $display("phase %0d mode %0d: %0d checks, %0d errors so far", p, ph[p].mode, n_checks, n_err);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read-side master for the dual-port framebuffer RAM. It drives RAM port b (address, wren, data) on the VGA clock.
- Generates 640x480@60 timing, with HS/VS active-low.
- Fetches one 16-bit RGB444 word per framebuffer pixel, with pixel replication of 2^SCALE_SHIFT in both axes.
- Emits pipeline-aligned VGA_R/G/B, HS and VS to the pins. The CPU writes the framebuffer through port a; this block is the matching reader.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SCALE_SHIFT, 2, log2 of the pixel replication factor
- FB_WIDTH, 160, framebuffer words per row (H_ACTIVE >> SCALE_SHIFT)
- FB_BASE, 16'h0000, word address of framebuffer pixel (0,0)
- RD_LATENCY, 1, clocks from address sampled by RAM to q valid (1..3)

Ports:
- clock  in  1  VGA pixel clock (25 MHz, PLL c1)
- reset_n  in  1  asynchronous active-low reset
- address  out  16  RAM port b word address, registered
- wren  out  1  RAM port b write enable, constant 0
- data  out  16  RAM port b write data, constant 0
- q  in  16  RAM port b read data; [11:8]=R, [7:4]=G, [3:0]=B, [15:12] ignored
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- HS  out  1  horizontal sync, active-low
- VS  out  1  vertical sync, active-low
- frame_start  out  1  one-cycle pulse at start of vertical blanking (aligned with outputs)

Behaviour:
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - vcnt runs 0..V_TOTAL-1, where V_TOTAL = 525. vcnt advances when hcnt wraps, and both wrap to 0 together.
- Raw timing at counter stage:
  - active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hs_n = 0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_n = 0 iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
  - fs = (hcnt==0 && vcnt==V_ACTIVE).
- Address generation (no multiplier):
  - address = row_base + col, computed mod 2^16.
  - col resets to 0 when hcnt wraps. It increments after each active hcnt whose low SCALE_SHIFT bits are all 1.
  - row_base is updated when hcnt wraps:
    - If vcnt == V_TOTAL-1: row_base = FB_BASE.
    - Else if vcnt < V_ACTIVE and the low SCALE_SHIFT bits of vcnt are all 1: row_base += FB_WIDTH.
  - During blanking, address equals row_base of the next line to display.
- Pipeline and latency:
  - PIPE = RD_LATENCY+2.
  - Counter state (h,v) in cycle t produces a registered address in t+1 and q valid in t+1+RD_LATENCY.
  - RGB is registered and visible in t+PIPE.
  - active, hs_n, vs_n and fs pass through a PIPE-deep shift register so that RGB, HS, VS and frame_start change in the same cycle.
- RGB output:
  - When the delayed active = 1, RGB = q fields.
  - Otherwise RGB = 0, regardless of q.
- Reset:
  - While reset_n = 0, all registers clear asynchronously.
  - Counter and address values: hcnt = vcnt = col = 0, row_base = FB_BASE, address = FB_BASE.
  - Output values: RGB = 0, HS = VS = 1, frame_start = 0.
  - Pipeline stages clear to active = 0, hs_n = vs_n = 1, fs = 0.
- Reset release: the first rising clock edge after release starts pixel (0,0). Assertion mid-frame aborts the frame, and the next frame restarts at (0,0). No partial sync pulse may extend past reset.
- RAM port b writes: wren = 0 and data = 0 at all times, including during reset.

Test Plan:
- Reset, check outputs: hold reset_n = 0 for 5 clocks with q = 16'hFFFF -> RGB = 0, HS = VS = 1, address = 0, wren = 0, frame_start = 0.
- Reset, check timing: on release with RD_LATENCY = 1 (PIPE = 3), the first HS fall occurs 656+3 clocks after the first edge. HS is low for 96 clocks with an 800-clock period. VS is low for 1600 clocks with a 420000-clock period.
- Address sequence:
  - Line 0 reads 0,0,0,0,1,1,1,1,...,159, and lines 1–3 repeat it exactly.
  - Line 4 starts at 160, and line 479 ends at 19199.
  - Vertical blanking holds address 0, and the next frame restarts at 0.
- Data alignment: the RAM model returns q = 16'h0ABC at address 161 and 0 elsewhere -> RGB = (A,B,C) exactly for x = 4..7, y = 4..7, first appearing PIPE clocks after the counter reaches (4,4). Repeat with RD_LATENCY = 2 and check the shift to PIPE = 4.
- Blanking: q = 16'hFFFF constant -> RGB = F,F,F only inside the delayed 640x480 window and 0 in all porch and sync cycles. frame_start pulses once per frame, coincident with the first blank output line.
- Mid-frame reset: assert reset_n = 0 at line 200, pixel 300 for 3 clocks -> all outputs return to reset values immediately. After release, the address sequence and HS timing restart from (0,0) exactly as in the reset-timing test.
